boot_sequencer: RTL
===================

Name: boot_sequencer

Overview:
- Protocol controller between the UART byte FIFO and instruction memory for serial boot.
- Parses one framed image: sync byte, 16-bit word count, little-endian payload words, XOR checksum.
- Writes payload words sequentially into IMEM.
- Holds the CPU in reset until the image is validated, then releases it. Reports done or error status with a cause code.

Parameters:
- IMEM_DEPTH, 1024, number of 32-bit IMEM words; also the maximum legal word count.
- ADDR_W, 10, IMEM word address width; must equal clog2(IMEM_DEPTH).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1_000_000, maximum clk cycles allowed between accepted bytes once a frame has started.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  synchronous reset, active-high.
- byte_data  input  8  byte from the FIFO read side.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_ready  output  1  controller accepts the byte this cycle. A transfer occurs when byte_valid and byte_ready are both high.
- rearm  input  1  one-cycle pulse: return from DONE or ERROR to SYNC and re-hold the CPU.
- imem_wr_en  output  1  one-cycle IMEM write strobe.
- imem_wr_addr  output  ADDR_W  IMEM word address.
- imem_wr_data  output  32  IMEM write data.
- cpu_rst_hold  output  1  high holds the CPU in reset.
- boot_done  output  1  image loaded and checksum passed.
- boot_error  output  1  frame rejected.
- err_code  output  2  error cause: 0 = none, 1 = bad length, 2 = checksum, 3 = timeout.

Behaviour:
- Reset values: state SYNC, byte_ready 0, imem_wr_en 0, imem_wr_addr 0, imem_wr_data 0, cpu_rst_hold 1, boot_done 0, boot_error 0, err_code 0. All internal counters and the checksum clear to 0.
- byte_ready is registered. It is 1 in SYNC, LEN_LO, LEN_HI, PAYLOAD and CKSUM, and 0 in DONE and ERROR. It goes to 0 in the cycle after the final checksum byte is accepted.
- Transfers: all state changes are driven only by accepted transfers, except timeout and rearm.
- SYNC state:
  - A byte equal to SYNC_BYTE moves to LEN_LO, clears the checksum to 0 and clears the word address to 0.
  - Any other byte is discarded and the state stays SYNC. The timeout is not armed in SYNC.
- LEN_LO state: stores count[7:0], XORs the byte into the checksum, moves to LEN_HI.
- LEN_HI state:
  - Stores count[15:8] and XORs the byte into the checksum.
  - If count is 0 or count > IMEM_DEPTH: go to ERROR with err_code 1.
  - Otherwise: go to PAYLOAD.
- PAYLOAD state:
  - Bytes assemble little-endian, first byte into bits [7:0]. Every byte is XORed into the checksum.
  - On the 4th byte: imem_wr_en = 1 in the next cycle, with the assembled word on imem_wr_data and the current address on imem_wr_addr. Latency is 1 cycle from the 4th-byte transfer to the strobe.
  - The address then increments.
  - After word number count has been written, move to CKSUM.
  - Write addresses run 0..count-1 and never wrap, because count ≤ IMEM_DEPTH is enforced in LEN_HI.
- CKSUM state (next byte accepted):
  - If byte == running XOR: go to DONE, set boot_done = 1 and cpu_rst_hold = 0 in the same registered update.
  - Otherwise: go to ERROR with err_code 2.
- DONE state: outputs are sticky and no bytes are accepted.
- ERROR state:
  - boot_error = 1, cpu_rst_hold = 1, no bytes accepted.
  - IMEM contents already written are left as they are.
- Timeout:
  - In LEN_LO, LEN_HI, PAYLOAD and CKSUM, an idle counter increments each cycle with no transfer and clears on every transfer.
  - When it reaches TIMEOUT_CYCLES-1: go to ERROR with err_code 3.
  - If a transfer arrives in the same cycle the count would expire, the transfer wins.
- rearm:
  - Honoured only in DONE or ERROR; ignored in every other state.
  - Effect: go to SYNC, clear boot_done, boot_error and err_code, and set cpu_rst_hold = 1.
- rst has priority over every other input in every state. A reset mid-frame abandons the frame with no further IMEM writes.
- imem_wr_en is never high in two consecutive cycles, since at least 4 transfers separate two writes.

Test Plan:
- Frame A5, 02, 00, 13 00 00 00, 93 00 10 00, chk: imem writes 0x00000013 @0 and 0x00100093 @1. Send chk = 02^00^13^93^10 = 0x92 -> boot_done = 1, cpu_rst_hold = 0 on the cycle after chk.
- Garbage bytes 00 FF 5A, then the valid 1-word frame A5 01 00 EF BE AD DE, chk = 0x01^0xEF^0xBE^0xAD^0xDE = 0x23 -> garbage ignored, single write 0xDEADBEEF @0, boot_done = 1.
- Length cases:
  - A5 00 00 -> boot_error = 1, err_code = 1, no writes.
  - A5 01 04 (count 1025) -> err_code = 1.
  - A5 00 04 (count 1024) -> accepted.
- Valid 1-word frame with checksum off by one -> writes occur, then boot_error = 1, err_code = 2, cpu_rst_hold stays 1. Then rearm pulse plus a valid frame -> boot_done = 1, err_code = 0.
- TIMEOUT_CYCLES = 16: send A5 01, then stall -> err_code = 3 exactly 15 idle cycles after the last transfer. A byte arriving on the expiry cycle -> no error.
- rst asserted after 2 payload bytes -> next cycle shows every output at its reset value, and a following valid frame writes from address 0.

Source files
------------

// File: rtl/boot_sequencer.sv
// Serial boot loader: parses one framed image from the UART byte FIFO,
// writes its payload words into IMEM and releases the CPU once the XOR checksum matches.
module boot_sequencer #(
  parameter int         IMEM_DEPTH     = 1024,
  parameter int         ADDR_W         = 10,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              rearm,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic              cpu_rst_hold,
  output logic              boot_done,
  output logic              boot_error,
  output logic [1:0]        err_code
);

  localparam logic [2:0] S_SYNC    = 3'd0;
  localparam logic [2:0] S_LEN_LO  = 3'd1;
  localparam logic [2:0] S_LEN_HI  = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CKSUM   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  localparam int               IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  // The idle counter expires on the edge where it would reach TIMEOUT_CYCLES-1.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 2);
  localparam logic [16:0]      DEPTH_17  = 17'(IMEM_DEPTH);

  logic [2:0]        state;
  logic [15:0]       word_count;
  logic [7:0]        cksum;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   wr_cnt_next;
  logic [1:0]        byte_idx;
  logic [23:0]       word_buf;
  logic [IDLE_W-1:0] idle_cnt;
  logic              xfer;
  logic              in_frame;
  logic [15:0]       len_full;

  // Handshake: a byte moves only on a cycle where byte_valid and byte_ready are both high.
  assign xfer        = byte_valid & byte_ready;
  assign in_frame    = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_PAYLOAD) || (state == S_CKSUM);
  assign len_full    = {byte_data, word_count[7:0]};
  assign wr_cnt_next = wr_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_SYNC;
      byte_ready   <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      cpu_rst_hold <= 1'b1;
      boot_done    <= 1'b0;
      boot_error   <= 1'b0;
      err_code     <= 2'd0;
      word_count   <= '0;
      cksum        <= '0;
      wr_cnt       <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      idle_cnt     <= '0;
    end else begin
      imem_wr_en <= 1'b0;
      case (state)
        S_SYNC: begin
          byte_ready <= 1'b1;
          if (xfer && byte_data == SYNC_BYTE) begin
            state    <= S_LEN_LO;
            cksum    <= '0;
            wr_cnt   <= '0;
            byte_idx <= '0;
            idle_cnt <= '0;
          end
        end
        S_LEN_LO: if (xfer) begin
          word_count[7:0] <= byte_data;
          cksum           <= cksum ^ byte_data;
          state           <= S_LEN_HI;
        end
        S_LEN_HI: if (xfer) begin
          word_count <= len_full;
          cksum      <= cksum ^ byte_data;
          if (len_full == 16'd0 || {1'b0, len_full} > DEPTH_17) begin
            state      <= S_ERROR;
            boot_error <= 1'b1;
            err_code   <= 2'd1;
            byte_ready <= 1'b0;
          end else begin
            state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: if (xfer) begin
          cksum    <= cksum ^ byte_data;
          byte_idx <= byte_idx + 2'd1;
          case (byte_idx)
            2'd0: word_buf[7:0]   <= byte_data;
            2'd1: word_buf[15:8]  <= byte_data;
            2'd2: word_buf[23:16] <= byte_data;
            default: begin
              imem_wr_en   <= 1'b1;
              imem_wr_data <= {byte_data, word_buf};
              imem_wr_addr <= wr_cnt[ADDR_W-1:0];
              wr_cnt       <= wr_cnt_next;
              if (16'(wr_cnt_next) == word_count) state <= S_CKSUM;
            end
          endcase
        end
        S_CKSUM: if (xfer) begin
          byte_ready <= 1'b0;
          if (byte_data == cksum) begin
            state        <= S_DONE;
            boot_done    <= 1'b1;
            cpu_rst_hold <= 1'b0;
          end else begin
            state      <= S_ERROR;
            boot_error <= 1'b1;
            err_code   <= 2'd2;
          end
        end
        S_DONE, S_ERROR: begin
          byte_ready <= 1'b0;
          if (rearm) begin
            state        <= S_SYNC;
            byte_ready   <= 1'b1;
            boot_done    <= 1'b0;
            boot_error   <= 1'b0;
            err_code     <= 2'd0;
            cpu_rst_hold <= 1'b1;
          end
        end
        default: state <= S_SYNC;
      endcase

      // Idle watchdog; an accepted byte on the expiry cycle takes precedence.
      if (in_frame) begin
        if (xfer) begin
          idle_cnt <= '0;
        end else if (idle_cnt >= IDLE_LAST) begin
          state      <= S_ERROR;
          boot_error <= 1'b1;
          err_code   <= 2'd3;
          byte_ready <= 1'b0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule
